// File: rtl/bram_pkg.sv
// Shared types and helpers for the simple dual-port block RAM family.
package bram_pkg;

    localparam int BRAM_MAX_WIDTH = 1024;

    typedef logic [BRAM_MAX_WIDTH-1:0] bram_word_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } bram_clr_state_e;

    // Lane-wise select: lane i comes from new_word when be[i] is set, else from old_word.
    function automatic bram_word_t byte_merge(
        input bram_word_t old_word,
        input bram_word_t new_word,
        input bram_word_t be,
        input int         byte_width = 8
    );
        bram_word_t merged;
        logic [9:0] lane;
        merged = old_word;
        for (int i = 0; i < BRAM_MAX_WIDTH; i++) begin
            lane = 10'(i / byte_width);
            if (be[lane]) begin
                merged[i[9:0]] = new_word[i[9:0]];
            end else begin
                merged[i[9:0]] = old_word[i[9:0]];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port BRAM: byte write enables, 1/2-cycle read latency, clear-after-reset.
// Optional write-to-read forwarding on same-address collision: define BRAM_SDP_BYPASS_EN.
module bram_sdp
    import bram_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 4,
    parameter int                    BYTE_WIDTH   = 8,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              init_busy,
    input  logic                              we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]  wbe,
    input  logic [ADDR_WIDTH-1:0]             waddr,
    input  logic [DATA_WIDTH-1:0]             wdata,
    input  logic                              re,
    input  logic [ADDR_WIDTH-1:0]             raddr,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic                              rvalid
);

    localparam int                    NBYTES    = DATA_WIDTH / BYTE_WIDTH;
    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("bram_sdp: READ_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % BYTE_WIDTH) != 0 || DATA_WIDTH > BRAM_MAX_WIDTH) begin : g_bad_width
        $error("bram_sdp: DATA_WIDTH must be a multiple of BYTE_WIDTH and fit byte_merge");
    end

    bram_clr_state_e         state_r;
    bram_clr_state_e         state_next_s;
    logic [ADDR_WIDTH-1:0]   clr_cnt_r;
    logic [ADDR_WIDTH-1:0]   clr_cnt_next_s;
    logic                    init_busy_r;
    logic                    clr_we_s;
    logic                    usr_we_s;
    logic                    usr_re_s;
    logic [DATA_WIDTH-1:0]   merged_wr_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic                    rvalid_r;
    logic [NBYTES-1:0]       wbe_s;

    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    assign wbe_s    = wbe;
    assign clr_we_s = (state_r == CLEAR);
    assign usr_we_s = (state_r == READY) && we;
    assign usr_re_s = (state_r == READY) && re;

    assign merged_wr_s = DATA_WIDTH'(byte_merge(bram_word_t'(mem_r[waddr]),
                                                bram_word_t'(wdata),
                                                bram_word_t'(wbe_s),
                                                BYTE_WIDTH));

    // Clear sequencer next-state: walk every address once, then park in READY.
    always_comb begin
        state_next_s   = state_r;
        clr_cnt_next_s = clr_cnt_r;
        case (state_r)
            CLEAR: begin
                clr_cnt_next_s = clr_cnt_r + ADDR_WIDTH'(1);
                if (clr_cnt_r == LAST_ADDR) begin
                    state_next_s = READY;
                end else begin
                    state_next_s = CLEAR;
                end
            end
            READY: begin
                state_next_s = READY;
            end
            default: begin
                state_next_s   = CLEAR;
                clr_cnt_next_s = '0;
            end
        endcase
    end

    // Clear sequencer state, counter and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= CLEAR;
            clr_cnt_r   <= '0;
            init_busy_r <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            clr_cnt_r   <= clr_cnt_next_s;
            init_busy_r <= (state_next_s == CLEAR);
        end
    end

    // Memory array write port; no reset so the array still maps onto BRAM.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_cnt_r] <= INIT_VALUE;
        end else if (usr_we_s) begin
            mem_r[waddr] <= merged_wr_s;
        end
    end

`ifdef BRAM_SDP_BYPASS_EN
    // Write-first on collision: the merged word is exactly what the write will store.
    always_comb begin
        rd_word_s = mem_r[raddr];
        if (usr_we_s && (waddr == raddr)) begin
            rd_word_s = merged_wr_s;
        end else begin
            rd_word_s = mem_r[raddr];
        end
    end
`else
    assign rd_word_s = mem_r[raddr];
`endif

    if (READ_LATENCY == 1) begin : g_lat1
        // Single read stage drives the outputs directly.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rvalid_r <= 1'b0;
                rdata_r  <= '0;
            end else begin
                rvalid_r <= usr_re_s;
                if (usr_re_s) begin
                    rdata_r <= rd_word_s;
                end
            end
        end
    end else begin : g_lat2
        logic                  s1_valid_r;
        logic [DATA_WIDTH-1:0] s1_data_r;

        // Array read stage followed by an output register; valid travels with the data.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_valid_r <= 1'b0;
                s1_data_r  <= '0;
                rvalid_r   <= 1'b0;
                rdata_r    <= '0;
            end else begin
                s1_valid_r <= usr_re_s;
                if (usr_re_s) begin
                    s1_data_r <= rd_word_s;
                end
                rvalid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    rdata_r <= s1_data_r;
                end
            end
        end
    end

    assign init_busy = init_busy_r;
    assign rdata     = rdata_r;
    assign rvalid    = rvalid_r;

endmodule
